// File: rtl/seq3_if.sv
// seq3_if: instruction/datapath bus between the program controller and seq3
// Signals:
//   inst      {op, A, B} instruction word (controller -> seq3)
//   inst_en   inst is valid this cycle
//   ireg      flattened input registers, ireg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   next      address of the next instruction to fetch (seq3 -> controller)
//   oreg      {oreg index, data} of the last register write
//   oreg_wen  one-hot write strobe over NUM_OREGS
//   busy      sequencer is waiting on an input register
//   error     sequencer is in the absorbing error state
// Modports: master = controller side, slave = seq3 side.
interface seq3_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_IREGS      = 4,
    parameter int NUM_OREGS      = 8,
    parameter int OREG_SEL_WIDTH = 3
);
    logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] inst;
    logic                               inst_en;
    logic [NUM_IREGS*DATA_WIDTH-1:0]    ireg;
    logic [ADDR_WIDTH-1:0]              next;
    logic [OREG_SEL_WIDTH+DATA_WIDTH-1:0] oreg;
    logic [NUM_OREGS-1:0]               oreg_wen;
    logic                               busy;
    logic                               error;
    modport master (output inst, inst_en, ireg, input next, oreg, oreg_wen, busy, error);
    modport slave  (input inst, inst_en, ireg, output next, oreg, oreg_wen, busy, error);
endinterface

// File: rtl/seq3.sv
// seq3: parametrised instruction sequencer with return-address stack
// Ports:
//   clock    rising-edge clock
//   reset    synchronous active-high reset
//   timeout  wait limit in cycles, 0 = unlimited (only with SEQ3_WAIT_TIMEOUT_EN)
//   bus      seq3_if.slave: inst/inst_en/ireg in, next/oreg/oreg_wen/busy/error out
// Optional feature macro: SEQ3_WAIT_TIMEOUT_EN adds the timeout port and Wait counter.
module seq3 #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_IREGS      = 4,
    parameter int IREG_SEL_WIDTH = 2,
    parameter int NUM_OREGS      = 8,
    parameter int OREG_SEL_WIDTH = 3,
    parameter int STACK_DEPTH    = 4,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input logic clock,
    input logic reset,
`ifdef SEQ3_WAIT_TIMEOUT_EN
    input logic [TIMEOUT_WIDTH-1:0] timeout,
`endif
    seq3_if.slave bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [1:0] READY = 2'd0, WAIT = 2'd1, ERR = 2'd2;
    localparam logic [3:0] OP_NO = 4'h0, OP_CI = 4'h1, OP_CR = 4'h2, OP_JI = 4'h3,
                           OP_JR = 4'h4, OP_JZ = 4'h5, OP_JN = 4'h6, OP_WN = 4'h7,
                           OP_WZ = 4'h8, OP_CL = 4'h9, OP_RT = 4'hA;
    logic [1:0]                state;
    logic [3:0]                op;
    logic [ADDR_WIDTH-1:0]     a, next_inc;
    logic [DATA_WIDTH-1:0]     b, r, wr;
    logic [IREG_SEL_WIDTH-1:0] sel, w_sel;
    logic [OREG_SEL_WIDTH-1:0] oidx;
    logic                      w_pol, sel_ok, oidx_ok, uses_r, cond, w_cond, full, empty, bad;
    logic [ADDR_WIDTH-1:0]     stack [STACK_DEPTH];
    logic [SP_W-1:0]           sp;
`ifdef SEQ3_WAIT_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0]  cnt;
`endif
    assign op       = bus.inst[4+ADDR_WIDTH+DATA_WIDTH-1 -: 4];
    assign a        = bus.inst[DATA_WIDTH +: ADDR_WIDTH];
    assign b        = bus.inst[DATA_WIDTH-1:0];
    assign sel      = b[IREG_SEL_WIDTH-1:0];
    assign oidx     = a[OREG_SEL_WIDTH-1:0];
    assign next_inc = bus.next + ADDR_WIDTH'(1);
    assign sel_ok   = int'(sel) < NUM_IREGS;
    assign oidx_ok  = int'(oidx) < NUM_OREGS;
    assign full     = sp == SP_W'(STACK_DEPTH);
    assign empty    = sp == '0;
    assign uses_r   = op inside {OP_CR, OP_JR, OP_JZ, OP_JN, OP_WN, OP_WZ};
    assign cond     = (op == OP_WN) ? (r != '0) : (r == '0);
    assign w_cond   = w_pol ? (wr != '0) : (wr == '0);
    assign bad      = (uses_r && !sel_ok) || ((op == OP_CI || op == OP_CR) && !oidx_ok) ||
                      (op == OP_CL && full) || (op == OP_RT && empty) || (op > OP_RT);
    assign bus.busy  = state == WAIT;
    assign bus.error = state == ERR;
    // Operand mux for the decoding instruction and for the latched Wait register.
    always_comb begin
        r  = '0;
        wr = '0;
        for (int k = 0; k < NUM_IREGS; k++) begin
            r  = (sel == IREG_SEL_WIDTH'(k)) ? bus.ireg[k*DATA_WIDTH +: DATA_WIDTH] : r;
            wr = (w_sel == IREG_SEL_WIDTH'(k)) ? bus.ireg[k*DATA_WIDTH +: DATA_WIDTH] : wr;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= READY;
            bus.next     <= '0;
            bus.oreg     <= '0;
            bus.oreg_wen <= '0;
            sp           <= '0;
            w_sel        <= '0;
            w_pol        <= 1'b0;
`ifdef SEQ3_WAIT_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            bus.oreg_wen <= '0;
            case (state)
                READY: if (bus.inst_en) begin
                    if (bad) state <= ERR;
                    else case (op)
                        OP_CI: begin
                            bus.oreg     <= {oidx, b};
                            bus.oreg_wen <= NUM_OREGS'(1) << oidx;
                            bus.next     <= next_inc;
                        end
                        OP_CR: begin
                            bus.oreg     <= {oidx, r};
                            bus.oreg_wen <= NUM_OREGS'(1) << oidx;
                            bus.next     <= next_inc;
                        end
                        OP_JI: bus.next <= a;
                        OP_JR: bus.next <= ADDR_WIDTH'(r);
                        OP_JZ: bus.next <= (r == '0) ? a : next_inc;
                        OP_JN: bus.next <= (r != '0) ? a : next_inc;
                        OP_WN, OP_WZ: begin
                            if (cond) bus.next <= next_inc;
                            else begin
                                state <= WAIT;
                                w_sel <= sel;
                                w_pol <= op == OP_WN;
`ifdef SEQ3_WAIT_TIMEOUT_EN
                                cnt   <= '0;
`endif
                            end
                        end
                        OP_CL: begin
                            stack[IDX_W'(sp)] <= next_inc;
                            sp                <= sp + SP_W'(1);
                            bus.next          <= a;
                        end
                        OP_RT: begin
                            bus.next <= stack[IDX_W'(sp - SP_W'(1))];
                            sp       <= sp - SP_W'(1);
                        end
                        default: bus.next <= next_inc;
                    endcase
                end
                WAIT: begin
                    // Exit needs inst_en; a satisfied condition alone keeps waiting.
                    if (bus.inst_en && w_cond) begin
                        state    <= READY;
                        bus.next <= next_inc;
                    end
`ifdef SEQ3_WAIT_TIMEOUT_EN
                    else if (timeout != '0 && cnt == timeout) state <= ERR;
                    else cnt <= cnt + TIMEOUT_WIDTH'(1);
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq3.sv
// tb_seq3: directed self-checking bench for seq3
module tb_seq3;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
`ifdef SEQ3_WAIT_TIMEOUT_EN
    logic [7:0] timeout = 8'd0;
`endif
    seq3_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_IREGS(4), .NUM_OREGS(8), .OREG_SEL_WIDTH(4)) bus_if ();
    seq3 #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_IREGS(4), .IREG_SEL_WIDTH(3), .NUM_OREGS(8),
           .OREG_SEL_WIDTH(4), .STACK_DEPTH(4), .TIMEOUT_WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
`ifdef SEQ3_WAIT_TIMEOUT_EN
        .timeout(timeout),
`endif
        .bus(bus_if.slave)
    );
    always #5 clock = ~clock;

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus_if.inst    = mk(op, a, b);
        bus_if.inst_en = 1'b1;
        tick();
        bus_if.inst_en = 1'b0;
    endtask

    task automatic set_ireg(input int k, input logic [7:0] v);
        bus_if.ireg[k*8 +: 8] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.inst_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_if.next !== 8'h00 || bus_if.oreg !== 12'h000 || bus_if.oreg_wen !== 8'h00 ||
            bus_if.busy !== 1'b0 || bus_if.error !== 1'b0) begin
            errors++;
            $display("FAIL reset: next=%h oreg=%h wen=%b busy=%b error=%b, want 00 000 00000000 0 0",
                     bus_if.next, bus_if.oreg, bus_if.oreg_wen, bus_if.busy, bus_if.error);
        end
    endtask

    task automatic test_writes();
        exec(4'h0, 8'h00, 8'h00);
        checks++;
        if (bus_if.next !== 8'h01 || bus_if.oreg_wen !== 8'h00) begin
            errors++;
            $display("FAIL no: next=%h wen=%b, want 01 00000000", bus_if.next, bus_if.oreg_wen);
        end
        exec(4'h1, 8'h02, 8'hAA);
        checks++;
        if (bus_if.next !== 8'h02 || bus_if.oreg !== 12'h2AA || bus_if.oreg_wen !== 8'b00000100) begin
            errors++;
            $display("FAIL ci: next=%h oreg=%h wen=%b, want 02 2aa 00000100", bus_if.next, bus_if.oreg, bus_if.oreg_wen);
        end
        set_ireg(1, 8'hAA);
        exec(4'h2, 8'h03, 8'h01);
        checks++;
        if (bus_if.next !== 8'h03 || bus_if.oreg !== 12'h3AA || bus_if.oreg_wen !== 8'b00001000) begin
            errors++;
            $display("FAIL cr: next=%h oreg=%h wen=%b, want 03 3aa 00001000", bus_if.next, bus_if.oreg, bus_if.oreg_wen);
        end
        tick();
        checks++;
        if (bus_if.next !== 8'h03 || bus_if.oreg !== 12'h3AA || bus_if.oreg_wen !== 8'h00) begin
            errors++;
            $display("FAIL idle: next=%h oreg=%h wen=%b, want 03 3aa 00000000", bus_if.next, bus_if.oreg, bus_if.oreg_wen);
        end
    endtask

    task automatic test_jumps();
        logic [7:0] want [5] = '{8'hA0, 8'hBA, 8'hE0, 8'hE1, 8'h40};
        set_ireg(0, 8'h10);
        set_ireg(2, 8'hBA);
        set_ireg(3, 8'h00);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: exec(4'h3, 8'hA0, 8'h00);
                1: exec(4'h4, 8'h00, 8'h02);
                2: exec(4'h5, 8'hE0, 8'h03);
                3: exec(4'h5, 8'hF0, 8'h00);
                default: exec(4'h6, 8'h40, 8'h00);
            endcase
            checks++;
            if (bus_if.next !== want[i] || bus_if.error !== 1'b0) begin
                errors++;
                $display("FAIL jump%0d: next=%h error=%b, want %h 0", i, bus_if.next, bus_if.error, want[i]);
            end
        end
    endtask

    task automatic test_wait();
        set_ireg(1, 8'h00);
        exec(4'h7, 8'h00, 8'h01);
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.next !== 8'h40) begin
            errors++;
            $display("FAIL wn_enter: busy=%b next=%h, want 1 40", bus_if.busy, bus_if.next);
        end
        set_ireg(1, 8'h01);
        tick();
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.next !== 8'h40) begin
            errors++;
            $display("FAIL wn_no_en: busy=%b next=%h, want 1 40", bus_if.busy, bus_if.next);
        end
        exec(4'hF, 8'hFF, 8'hFF);
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.next !== 8'h41 || bus_if.error !== 1'b0) begin
            errors++;
            $display("FAIL wn_exit: busy=%b next=%h error=%b, want 0 41 0", bus_if.busy, bus_if.next, bus_if.error);
        end
        set_ireg(3, 8'h00);
        exec(4'h8, 8'h00, 8'h03);
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.next !== 8'h42) begin
            errors++;
            $display("FAIL wz_pass: busy=%b next=%h, want 0 42", bus_if.busy, bus_if.next);
        end
    endtask

    task automatic test_stack();
        logic [7:0] ret [4] = '{8'h41, 8'h31, 8'h21, 8'h11};
        exec(4'h3, 8'h10, 8'h00);
        for (int i = 0; i < 4; i++) begin
            exec(4'h9, 8'h20 + 8'(i) * 8'h10, 8'h00);
            checks++;
            if (bus_if.next !== 8'h20 + 8'(i) * 8'h10 || bus_if.error !== 1'b0) begin
                errors++;
                $display("FAIL call%0d: next=%h error=%b, want %h 0", i, bus_if.next, bus_if.error, 8'h20 + 8'(i) * 8'h10);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exec(4'hA, 8'h00, 8'h00);
            checks++;
            if (bus_if.next !== ret[i] || bus_if.error !== 1'b0) begin
                errors++;
                $display("FAIL ret%0d: next=%h error=%b, want %h 0", i, bus_if.next, bus_if.error, ret[i]);
            end
        end
        for (int i = 0; i < 4; i++) exec(4'h9, 8'h60, 8'h00);
        exec(4'h9, 8'h70, 8'h00);
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.next !== 8'h60) begin
            errors++;
            $display("FAIL call_full: error=%b next=%h, want 1 60", bus_if.error, bus_if.next);
        end
        exec(4'h3, 8'hBB, 8'h00);
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.next !== 8'h60) begin
            errors++;
            $display("FAIL err_absorb: error=%b next=%h, want 1 60", bus_if.error, bus_if.next);
        end
        do_reset();
        exec(4'h3, 8'hBB, 8'h00);
        checks++;
        if (bus_if.error !== 1'b0 || bus_if.next !== 8'hBB) begin
            errors++;
            $display("FAIL err_recover: error=%b next=%h, want 0 bb", bus_if.error, bus_if.next);
        end
        do_reset();
        exec(4'hA, 8'h00, 8'h00);
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.next !== 8'h00) begin
            errors++;
            $display("FAIL ret_empty: error=%b next=%h, want 1 00", bus_if.error, bus_if.next);
        end
    endtask

    task automatic test_errors();
        do_reset();
        exec(4'h1, 8'h05, 8'h55);
        exec(4'hF, 8'h00, 8'h00);
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.oreg_wen !== 8'h00 || bus_if.next !== 8'h01 || bus_if.oreg !== 12'h555) begin
            errors++;
            $display("FAIL bad_op: error=%b wen=%b next=%h oreg=%h, want 1 00000000 01 555",
                     bus_if.error, bus_if.oreg_wen, bus_if.next, bus_if.oreg);
        end
        do_reset();
        exec(4'h1, 8'h09, 8'h77);
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.oreg_wen !== 8'h00 || bus_if.oreg !== 12'h000) begin
            errors++;
            $display("FAIL bad_oidx: error=%b wen=%b oreg=%h, want 1 00000000 000", bus_if.error, bus_if.oreg_wen, bus_if.oreg);
        end
        do_reset();
        exec(4'h4, 8'h00, 8'h05);
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.next !== 8'h00) begin
            errors++;
            $display("FAIL bad_sel: error=%b next=%h, want 1 00", bus_if.error, bus_if.next);
        end
        do_reset();
        exec(4'h3, 8'h33, 8'h00);
        set_ireg(2, 8'h00);
        exec(4'h7, 8'h00, 8'h02);
        do_reset();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.next !== 8'h00 || bus_if.error !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait: busy=%b next=%h error=%b, want 0 00 0", bus_if.busy, bus_if.next, bus_if.error);
        end
    endtask

`ifdef SEQ3_WAIT_TIMEOUT_EN
    task automatic test_timeout();
        timeout = 8'd5;
        do_reset();
        set_ireg(0, 8'h00);
        exec(4'h7, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus_if.busy !== 1'b1 || bus_if.error !== 1'b0) begin
            errors++;
            $display("FAIL to_pending: busy=%b error=%b, want 1 0", bus_if.busy, bus_if.error);
        end
        tick();
        checks++;
        if (bus_if.error !== 1'b1) begin
            errors++;
            $display("FAIL to_fire: error=%b, want 1", bus_if.error);
        end
        do_reset();
        exec(4'h7, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        set_ireg(0, 8'h01);
        exec(4'h0, 8'h00, 8'h00);
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.error !== 1'b0 || bus_if.next !== 8'h01) begin
            errors++;
            $display("FAIL to_exit: busy=%b error=%b next=%h, want 0 0 01", bus_if.busy, bus_if.error, bus_if.next);
        end
    endtask
`endif

    initial begin
        bus_if.inst    = '0;
        bus_if.inst_en = 1'b0;
        bus_if.ireg    = '0;
        #2;
        test_reset();
        test_writes();
        test_jumps();
        test_wait();
        test_stack();
        test_errors();
`ifdef SEQ3_WAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
